// File: rtl/frame_fetch_pkg.sv
// frame_fetch_pkg
//   Shared types and constants for the frame fetch path (SDRAM -> display FIFO).
//   Contents: fetch FSM state enum, display geometry, bus widths and a
//   saturating 16-bit increment used by the optional statistics counters.
package frame_fetch_pkg;

    localparam int DISP_W    = 320;
    localparam int DISP_H    = 240;
    localparam int PIX_W     = 16;
    localparam int SDRAM_AW  = 25;
    localparam int PIX_IDX_W = 17;
    localparam int CMD_LEN_W = 7;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ROOM,
        CMD,
        DATA,
        DRAIN
    } ff_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/frame_fetch_if.sv
// frame_fetch_if
//   Bundles the SDRAM read-command/read-data channel and the display FIFO
//   write side seen by frame_fetch.
//   master : the fetcher (drives cmd_*, wr_fifo, sdram_data)
//   slave  : the SDRAM controller + FIFO side (drives cmd_ready, rd_*, fifo_*)
//   Signals:
//     cmd_valid/cmd_ready/cmd_addr/cmd_len  burst read command handshake
//     rd_valid/rd_data                      read data beats
//     fifo_level/fifo_full                  FIFO write-side status
//     wr_fifo/sdram_data                    FIFO write strobe and data
interface frame_fetch_if
    import frame_fetch_pkg::*;
#(
    parameter int FIFO_LVL_W = 12
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [SDRAM_AW-1:0]   cmd_addr;
    logic [CMD_LEN_W-1:0]  cmd_len;
    logic                  rd_valid;
    logic [PIX_W-1:0]      rd_data;
    logic [FIFO_LVL_W-1:0] fifo_level;
    logic                  fifo_full;
    logic                  wr_fifo;
    logic [PIX_W-1:0]      sdram_data;

    modport master (
        output cmd_valid, cmd_addr, cmd_len, wr_fifo, sdram_data,
        input  cmd_ready, rd_valid, rd_data, fifo_level, fifo_full
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, wr_fifo, sdram_data,
        output cmd_ready, rd_valid, rd_data, fifo_level, fifo_full
    );
endinterface

// File: rtl/frame_fetch_beat_cnt.sv
// frame_fetch_beat_cnt
//   Counts read data beats within one burst and flags the last one.
//   Ports:
//     clk, rst   clock and asynchronous active-high reset
//     clear      restart the count (command accepted)
//     beat       a data beat is being consumed this cycle
//     last_beat  beat is high and it is the BURST_LEN-th beat of the burst
module frame_fetch_beat_cnt #(
    parameter int BURST_LEN = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic beat,
    output logic last_beat
);
    localparam int CW = $clog2(BURST_LEN);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (beat) begin
            // BURST_LEN is a power of two, so the counter wraps to 0 after the last beat
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_beat = beat && (cnt_q == CW'(BURST_LEN - 1));
endmodule

// File: rtl/frame_fetch.sv
// frame_fetch
//   Streams one frame of RGB565 pixels from SDRAM into the display FIFO using
//   fixed-length burst reads, one burst outstanding at a time, issued only
//   while the FIFO has room. Every frame_start restarts at FRAME_BASE.
//   Ports:
//     clk_sdram    SDRAM-domain clock
//     buffer_rst   asynchronous reset, active high (controller shares it)
//     frame_start  one-cycle (re)start pulse
//     bus          frame_fetch_if.master (command, read data, FIFO write side)
//     busy         not IDLE (includes drain)
//     frame_done   pulse with the last word's FIFO write
//     overflow     sticky: wr_fifo seen while fifo_full
//     frame_count, overflow_count  (only with FRAME_FETCH_STATS_EN defined)
//   Optional build macro: FRAME_FETCH_STATS_EN adds saturating statistics.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   IDLE      | no frame in progress, waiting for frame_start
//   WAIT_ROOM | waiting for FIFO level to allow another burst
//   CMD       | read command presented, waiting for cmd_ready
//   DATA      | receiving burst beats, forwarding them to the FIFO
//   DRAIN     | discarding remaining beats of an aborted burst
module frame_fetch
    import frame_fetch_pkg::*;
#(
    parameter logic [SDRAM_AW-1:0] FRAME_BASE   = 25'h0,
    parameter int                  FRAME_PIXELS = 76800,
    parameter int                  BURST_LEN    = 16,
    parameter int                  FIFO_DEPTH   = 4096,
    parameter int                  FIFO_LVL_W   = 12
) (
    input  logic          clk_sdram,
    input  logic          buffer_rst,
    input  logic          frame_start,
    frame_fetch_if.master bus,
    output logic          busy,
    output logic          frame_done,
    output logic          overflow
`ifdef FRAME_FETCH_STATS_EN
    ,
    output logic [15:0]   frame_count,
    output logic [15:0]   overflow_count
`endif
);
    // Two bursts of margin: fifo_level lags the writes we have already made.
    localparam logic [FIFO_LVL_W:0] ROOM_LVL = (FIFO_LVL_W + 1)'(FIFO_DEPTH - 2 * BURST_LEN);

    ff_state_e              state_q, state_d;
    logic [PIX_IDX_W-1:0]   pix_idx_q, pix_idx_d;
    logic                   wr_q, wr_d;
    logic [PIX_W-1:0]       data_q, data_d;
    logic                   done_q, done_d;
    logic                   ovf_q, ovf_d;

    logic                   room;
    logic                   cmd_accept;
    logic                   beat_in;
    logic                   last_beat;
    logic [PIX_IDX_W-1:0]   pix_next;
    logic                   frame_end;

    assign room       = ({1'b0, bus.fifo_level} <= ROOM_LVL);
    assign cmd_accept = (state_q == CMD) && bus.cmd_ready;
    assign beat_in    = bus.rd_valid && ((state_q == DATA) || (state_q == DRAIN));
    assign pix_next   = pix_idx_q + PIX_IDX_W'(BURST_LEN);
    assign frame_end  = (pix_next == PIX_IDX_W'(FRAME_PIXELS));

    frame_fetch_beat_cnt #(
        .BURST_LEN (BURST_LEN)
    ) u_beat_cnt (
        .clk       (clk_sdram),
        .rst       (buffer_rst),
        .clear     (cmd_accept),
        .beat      (beat_in),
        .last_beat (last_beat)
    );

    always_comb begin
        state_d   = state_q;
        pix_idx_d = pix_idx_q;
        wr_d      = 1'b0;
        data_d    = data_q;
        done_d    = 1'b0;
        ovf_d     = ovf_q | (wr_q & bus.fifo_full);

        unique case (state_q)
            IDLE: begin
                if (frame_start) begin
                    pix_idx_d = '0;
                    state_d   = WAIT_ROOM;
                end
            end
            WAIT_ROOM: begin
                if (frame_start) begin
                    pix_idx_d = '0;
                end else if (room) begin
                    state_d = CMD;
                end
            end
            CMD: begin
                if (cmd_accept) begin
                    // An accepted command must have its data consumed even if aborted.
                    if (frame_start) begin
                        pix_idx_d = '0;
                        state_d   = DRAIN;
                    end else begin
                        state_d = DATA;
                    end
                end else if (frame_start) begin
                    pix_idx_d = '0;
                    state_d   = WAIT_ROOM;
                end
            end
            DATA: begin
                if (frame_start) begin
                    // The beat arriving with frame_start is dropped, as is the rest.
                    pix_idx_d = '0;
                    state_d   = last_beat ? WAIT_ROOM : DRAIN;
                end else if (beat_in) begin
                    wr_d   = 1'b1;
                    data_d = bus.rd_data;
                    if (last_beat) begin
                        pix_idx_d = pix_next;
                        if (frame_end) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = WAIT_ROOM;
                        end
                    end
                end
            end
            DRAIN: begin
                if (frame_start) begin
                    pix_idx_d = '0;
                end
                if (last_beat) begin
                    state_d = WAIT_ROOM;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sdram or posedge buffer_rst) begin
        if (buffer_rst) begin
            state_q   <= IDLE;
            pix_idx_q <= '0;
            wr_q      <= 1'b0;
            data_q    <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pix_idx_q <= pix_idx_d;
            wr_q      <= wr_d;
            data_q    <= data_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
        end
    end

    // Address and length are zeroed outside CMD so every output reads 0 in reset.
    assign bus.cmd_valid  = (state_q == CMD);
    assign bus.cmd_addr   = (state_q == CMD) ? (FRAME_BASE + SDRAM_AW'(pix_idx_q)) : '0;
    assign bus.cmd_len    = (state_q == CMD) ? CMD_LEN_W'(BURST_LEN) : '0;
    assign bus.wr_fifo    = wr_q;
    assign bus.sdram_data = data_q;
    assign busy           = (state_q != IDLE);
    assign frame_done     = done_q;
    assign overflow       = ovf_q;

`ifdef FRAME_FETCH_STATS_EN
    logic [15:0] frame_cnt_q;
    logic [15:0] ovf_cnt_q;

    always_ff @(posedge clk_sdram or posedge buffer_rst) begin
        if (buffer_rst) begin
            frame_cnt_q <= '0;
            ovf_cnt_q   <= '0;
        end else begin
            if (done_q) begin
                frame_cnt_q <= sat_inc16(frame_cnt_q);
            end
            if (wr_q && bus.fifo_full) begin
                ovf_cnt_q <= sat_inc16(ovf_cnt_q);
            end
        end
    end

    assign frame_count    = frame_cnt_q;
    assign overflow_count = ovf_cnt_q;
`endif
endmodule

// File: tb/tb_frame_fetch.sv
module tb_frame_fetch;
    import frame_fetch_pkg::*;

    localparam logic [24:0] BASE   = 25'h100000;
    localparam int          NPIX   = 512;
    localparam int          BLEN   = 16;
    localparam int          NBURST = NPIX / BLEN;

    logic clk;
    logic rst;
    logic frame_start;
    logic busy;
    logic frame_done;
    logic overflow;
`ifdef FRAME_FETCH_STATS_EN
    logic [15:0] frame_count;
    logic [15:0] overflow_count;
`endif

    int errors;
    int checks;
    int wr_count;
    int done_count;

    frame_fetch_if #(.FIFO_LVL_W(12)) ifc ();

    frame_fetch #(
        .FRAME_BASE   (BASE),
        .FRAME_PIXELS (NPIX),
        .BURST_LEN    (BLEN),
        .FIFO_DEPTH   (4096),
        .FIFO_LVL_W   (12)
    ) dut (
        .clk_sdram   (clk),
        .buffer_rst  (rst),
        .frame_start (frame_start),
        .bus         (ifc.master),
        .busy        (busy),
        .frame_done  (frame_done),
        .overflow    (overflow)
`ifdef FRAME_FETCH_STATS_EN
        ,
        .frame_count    (frame_count),
        .overflow_count (overflow_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ifc.wr_fifo === 1'b1) wr_count++;
        if (frame_done === 1'b1) done_count++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pat(input logic [24:0] a, input int b);
        logic [15:0] lo;
        lo = a[15:0];
        return lo ^ (16'h5A00 + 16'(b));
    endfunction

    // One burst: wait for command, check it, optionally stall, accept, feed 16 beats.
    task automatic burst(input logic [24:0] exp_addr, input bit exp_done, input int stall,
                         input int full_beat, input int start_beat, input string tag);
        int n;
        n = 0;
        while (ifc.cmd_valid !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (ifc.cmd_valid !== 1'b1 || ifc.cmd_addr !== exp_addr || ifc.cmd_len !== 7'd16) begin
            errors++;
            $display("FAIL %s_cmd: valid=%b addr=%h len=%0d, expected valid=1 addr=%h len=16",
                     tag, ifc.cmd_valid, ifc.cmd_addr, ifc.cmd_len, exp_addr);
        end
        for (int s = 0; s < stall; s++) begin
            tick();
            checks++;
            if (ifc.cmd_valid !== 1'b1 || ifc.cmd_addr !== exp_addr || ifc.cmd_len !== 7'd16) begin
                errors++;
                $display("FAIL %s_stall%0d: valid=%b addr=%h, expected valid=1 addr=%h",
                         tag, s, ifc.cmd_valid, ifc.cmd_addr, exp_addr);
            end
        end
        ifc.cmd_ready = 1'b1;
        tick();
        ifc.cmd_ready = 1'b0;
        checks++;
        if (ifc.cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_accept: valid=%b after accept, expected 0", tag, ifc.cmd_valid);
        end
        tick();
        tick();
        for (int b = 0; b < BLEN; b++) begin
            ifc.rd_valid = 1'b1;
            ifc.rd_data  = pat(exp_addr, b);
            frame_start  = (b == start_beat);
            tick();
            frame_start   = 1'b0;
            ifc.fifo_full = (b == full_beat);
            checks++;
            if (start_beat >= 0 && b >= start_beat) begin
                if (ifc.wr_fifo !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_drop%0d: wr_fifo=%b, expected 0", tag, b, ifc.wr_fifo);
                end
            end else if (ifc.wr_fifo !== 1'b1 || ifc.sdram_data !== pat(exp_addr, b)) begin
                errors++;
                $display("FAIL %s_beat%0d: wr_fifo=%b data=%h, expected wr_fifo=1 data=%h",
                         tag, b, ifc.wr_fifo, ifc.sdram_data, pat(exp_addr, b));
            end
        end
        ifc.rd_valid = 1'b0;
        ifc.rd_data  = '0;
        checks++;
        if (frame_done !== exp_done || busy !== !exp_done) begin
            errors++;
            $display("FAIL %s_end: frame_done=%b busy=%b, expected frame_done=%b busy=%b",
                     tag, frame_done, busy, exp_done, !exp_done);
        end
        tick();
        ifc.fifo_full = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if (ifc.cmd_valid !== 1'b0 || ifc.cmd_addr !== 25'h0 || ifc.cmd_len !== 7'h0 ||
            ifc.wr_fifo !== 1'b0 || ifc.sdram_data !== 16'h0 || busy !== 1'b0 ||
            frame_done !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL %s: valid=%b addr=%h len=%h wr=%b data=%h busy=%b done=%b ovf=%b, expected all 0",
                     tag, ifc.cmd_valid, ifc.cmd_addr, ifc.cmd_len, ifc.wr_fifo, ifc.sdram_data,
                     busy, frame_done, overflow);
        end
    endtask

    task automatic test_reset();
        int w0;
        rst = 1'b1;
        tick();
        tick();
        check_all_zero("reset_outputs");
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_wins: busy=%b, expected 0", busy);
        end
        rst = 1'b0;
        w0 = wr_count;
        ifc.rd_valid = 1'b1;
        ifc.rd_data  = 16'hBEEF;
        for (int i = 0; i < 4; i++) tick();
        ifc.rd_valid = 1'b0;
        tick();
        checks++;
        if (wr_count !== w0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_rd_ignored: writes=%0d busy=%b, expected writes=0 busy=0",
                     wr_count - w0, busy);
        end
    endtask

    task automatic test_full_frame();
        int w0;
        int d0;
        w0 = wr_count;
        d0 = done_count;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < NBURST; i++) begin
            burst(BASE + 25'(BLEN * i), (i == NBURST - 1), 0, -1, -1, "frame");
        end
        checks++;
        if (wr_count - w0 !== NPIX || done_count - d0 !== 1) begin
            errors++;
            $display("FAIL frame_totals: writes=%0d done=%0d, expected writes=%0d done=1",
                     wr_count - w0, done_count - d0, NPIX);
        end
        checks++;
        if (busy !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL frame_idle: busy=%b frame_done=%b, expected 0 0", busy, frame_done);
        end
`ifdef FRAME_FETCH_STATS_EN
        checks++;
        if (frame_count !== 16'd1) begin
            errors++;
            $display("FAIL frame_count: got %0d, expected 1", frame_count);
        end
`endif
    endtask

    task automatic test_wait_room();
        int seen;
        ifc.fifo_level = 12'd4065;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ifc.cmd_valid !== 1'b0 || busy !== 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL wait_room_hold: %0d bad cycles, expected cmd_valid=0 busy=1 in all 8", seen);
        end
        ifc.fifo_level = 12'd4064;
        tick();
        checks++;
        if (ifc.cmd_valid !== 1'b1) begin
            errors++;
            $display("FAIL wait_room_release: cmd_valid=%b, expected 1", ifc.cmd_valid);
        end
        ifc.fifo_level = 12'd0;
    endtask

    task automatic test_stall();
        burst(BASE, 1'b0, 10, -1, -1, "stall");
    endtask

    task automatic test_abort();
        int w0;
        int d0;
        burst(BASE + 25'd16, 1'b0, 0, -1, -1, "pre_abort");
        w0 = wr_count;
        d0 = done_count;
        burst(BASE + 25'd32, 1'b0, 0, -1, 5, "abort");
        checks++;
        if (wr_count - w0 !== 5 || done_count !== d0) begin
            errors++;
            $display("FAIL abort_writes: writes=%0d done=%0d, expected writes=5 done=0",
                     wr_count - w0, done_count - d0);
        end
    endtask

    task automatic test_overflow();
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_pre: got %b, expected 0", overflow);
        end
        burst(BASE, 1'b0, 0, 3, -1, "ovf");
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky: got %b, expected 1", overflow);
        end
`ifdef FRAME_FETCH_STATS_EN
        checks++;
        if (overflow_count !== 16'd1) begin
            errors++;
            $display("FAIL overflow_count: got %0d, expected 1", overflow_count);
        end
`endif
    endtask

    task automatic test_rst_mid_data();
        int n;
        int w0;
        int nv;
        n = 0;
        while (ifc.cmd_valid !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        ifc.cmd_ready = 1'b1;
        tick();
        ifc.cmd_ready = 1'b0;
        tick();
        tick();
        for (int b = 0; b < 3; b++) begin
            ifc.rd_valid = 1'b1;
            ifc.rd_data  = pat(BASE + 25'd16, b);
            tick();
        end
        checks++;
        if (ifc.wr_fifo !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: wr_fifo=%b busy=%b, expected 1 1", ifc.wr_fifo, busy);
        end
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid_data");
        w0 = wr_count;
        tick();
        rst = 1'b0;
        ifc.cmd_ready = 1'b1;
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ifc.cmd_valid === 1'b1) nv++;
        end
        ifc.rd_valid  = 1'b0;
        ifc.cmd_ready = 1'b0;
        tick();
        checks++;
        if (wr_count !== w0 || nv !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_quiet: writes=%0d cmd_cycles=%0d busy=%b, expected 0 0 0",
                     wr_count - w0, nv, busy);
        end
`ifdef FRAME_FETCH_STATS_EN
        checks++;
        if (overflow_count !== 16'd0 || frame_count !== 16'd0) begin
            errors++;
            $display("FAIL stats_rst: frame_count=%0d overflow_count=%0d, expected 0 0",
                     frame_count, overflow_count);
        end
`endif
    endtask

    task automatic test_final_beat_abort();
        int d0;
        int n;
        d0 = done_count;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < NBURST - 1; i++) begin
            burst(BASE + 25'(BLEN * i), 1'b0, 0, -1, -1, "fb");
        end
        burst(BASE + 25'(BLEN * (NBURST - 1)), 1'b0, 0, -1, BLEN - 1, "fb_last");
        n = 0;
        while (ifc.cmd_valid !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (ifc.cmd_valid !== 1'b1 || ifc.cmd_addr !== BASE || done_count !== d0) begin
            errors++;
            $display("FAIL final_beat_restart: valid=%b addr=%h done=%0d, expected valid=1 addr=%h done=0",
                     ifc.cmd_valid, ifc.cmd_addr, done_count - d0, BASE);
        end
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        rst            = 1'b1;
        frame_start    = 1'b0;
        ifc.cmd_ready  = 1'b0;
        ifc.rd_valid   = 1'b0;
        ifc.rd_data    = '0;
        ifc.fifo_level = '0;
        ifc.fifo_full  = 1'b0;

        test_reset();
        test_full_frame();
        test_wait_room();
        test_stall();
        test_abort();
        test_overflow();
        test_rst_mid_data();
        test_final_beat_abort();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
